// File: rtl/gate_chain_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// gate_chain_accumulator_pkg
// Shared types and constants for the gate-chain accumulator slice.
//   word_t  : signed fixed-point component, WIDTH bits, FRAC_BITS fractional
//   cplx_t  : complex value, index 0 = real, 1 = imaginary
//   mtx2_t  : 2x2 complex matrix, indexed [row][col][re/im]
//   FIX_ONE : fixed-point 1.0
//   MTX_IDENTITY : 2x2 identity matrix
//   ST_*    : FSM state encodings
// -----------------------------------------------------------------------------
package gate_chain_accumulator_pkg;

    localparam int WIDTH     = 19;
    localparam int FRAC_BITS = 16;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef word_t [1:0]             cplx_t;
    typedef cplx_t [1:0][1:0]        mtx2_t;

    localparam word_t FIX_ONE = word_t'(1 << FRAC_BITS);

    function automatic mtx2_t identity_mtx();
        mtx2_t m;
        m          = '0;
        m[0][0][0] = FIX_ONE;
        m[1][1][0] = FIX_ONE;
        return m;
    endfunction

    localparam mtx2_t MTX_IDENTITY = identity_mtx();

    // FSM encodings, kept as plain constants for legacy tooling.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_RESULT = 3'd3;
    localparam state_t ST_ERROR  = 3'd4;

endpackage

// File: rtl/gate_chain_accumulator_timeout.sv
// -----------------------------------------------------------------------------
// gate_chain_timeout
// Watchdog counter for the multiplier wait phase.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   clear   : zero the counter (takes priority over enable)
//   enable  : count this cycle
//   expired : high in the cycle whose increment would reach TIMEOUT, so the
//             owner can leave exactly TIMEOUT cycles after counting began
// -----------------------------------------------------------------------------
module gate_chain_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gate_chain_accumulator.sv
// -----------------------------------------------------------------------------
// gate_chain_accumulator
// Sequences a stream of 2x2 complex gates through an external matrix
// multiplier, folding each into a running product ACC <= G * ACC that starts
// at identity. When the gate flagged last has been applied, the fused matrix
// is offered downstream; after it is acknowledged ACC returns to identity.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   gate_mtx          : incoming gate [row][col][re/im]
//   gate_valid/last   : gate qualifier / closes the chain
//   gate_ready        : block accepts a gate this cycle (state IDLE)
//   mul_a, mul_b      : multiplier operands (latched gate, accumulator)
//   mul_start         : one-cycle start pulse
//   mul_done, mul_r   : multiplier completion pulse and product
//   result_mtx        : fused matrix (the accumulator)
//   result_valid/ack  : result offer / downstream consume
//   gate_count        : gates applied in the current chain, saturating
//   error             : sticky multiplier timeout, cleared only by reset
//   state_dbg         : current FSM state
//
// Handshakes: a gate transfers on a rising edge where gate_valid && gate_ready;
// a result transfers on a rising edge where result_valid && result_ack.
// Valid may not depend on ready/ack; ack without valid is ignored.
// -----------------------------------------------------------------------------
module gate_chain_accumulator
    import gate_chain_accumulator_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  mtx2_t            gate_mtx,
    input  logic             gate_valid,
    input  logic             gate_last,
    output logic             gate_ready,
    output mtx2_t            mul_a,
    output mtx2_t            mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  mtx2_t            mul_r,
    output mtx2_t            result_mtx,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] gate_count,
    output logic             error,
    output state_t           state_dbg
);

    state_t state;
    mtx2_t  acc;
    mtx2_t  gate_q;
    logic   last_flag;
    logic   wd_expired;

    gate_chain_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_START),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            acc        <= MTX_IDENTITY;
            gate_q     <= '0;
            last_flag  <= 1'b0;
            gate_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gate_valid) begin
                        gate_q    <= gate_mtx;
                        last_flag <= gate_last;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done arriving in the final watchdog cycle still wins.
                    if (mul_done) begin
                        acc <= mul_r;
                        if (gate_count != '1) begin
                            gate_count <= gate_count + 1'b1;
                        end
                        state <= last_flag ? ST_RESULT : ST_IDLE;
                    end else if (wd_expired) begin
                        state <= ST_ERROR;
                    end
                end
                ST_RESULT: begin
                    if (result_ack) begin
                        acc        <= MTX_IDENTITY;
                        gate_count <= '0;
                        state      <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

    // Gated by reset so the port reads 0 while reset is held low.
    assign gate_ready   = (state == ST_IDLE) && reset;
    assign mul_start    = (state == ST_START);
    assign result_valid = (state == ST_RESULT);
    assign error        = (state == ST_ERROR);
    assign mul_a        = gate_q;
    assign mul_b        = acc;
    assign result_mtx   = acc;
    assign state_dbg    = state;

endmodule
